// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC fine interpolator: count width helper,
// edge-polarity encodings and the bubble-corrected thermometer decoder.
package tdc_pkg;

    localparam int MAX_TAPS = 256;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic int fine_cw(input int n);
        return $clog2(n + 1);
    endfunction

    // Majority-of-three per tap removes single-tap bubbles; the chain is
    // bounded by an implied 1 below tap 0 and an implied 0 above the last tap.
    function automatic logic [8:0] tdc_therm2bin(input logic [MAX_TAPS-1:0] therm,
                                                 input int n);
        logic [8:0] acc;
        logic       lo;
        logic       mid;
        logic       hi;
        acc = '0;
        for (int k = 0; k < MAX_TAPS; k++) begin
            if (k < n) begin
                lo  = (k == 0) ? 1'b1 : therm[8'(k - 1)];
                mid = therm[8'(k)];
                hi  = (k + 1 < n) ? therm[8'(k + 1)] : 1'b0;
                acc = acc + 9'((lo & mid) | (lo & hi) | (mid & hi));
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/tdc_carry_chain.sv
// Tapped carry-chain delay line: the hit propagates through NUM_TAPS carry
// cells, tap k is the carry-out of cell k.
module tdc_carry_chain #(
    parameter int NUM_TAPS = 64
) (
    input  logic                signal_in,
    output logic [NUM_TAPS-1:0] taps
);

    (* keep *) logic [NUM_TAPS:0] carry;

    assign carry[0] = signal_in;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_cell
`ifdef TDC_USE_SB_CARRY
        (* keep *) SB_CARRY u_carry (
            .CO (carry[k+1]),
            .I0 (1'b0),
            .I1 (1'b1),
            .CI (carry[k])
        );
`else
        // Same function as SB_CARRY with I0=0, I1=1: CO = I0&I1 | CI&(I0|I1).
        (* keep *) logic co;
        assign co         = (1'b0 & 1'b1) | (carry[k] & (1'b0 | 1'b1));
        assign carry[k+1] = co;
`endif
        assign taps[k] = carry[k+1];
    end

endmodule

// File: rtl/tdc_fine_interp.sv
// Fine-time interpolator: tap capture, bubble-corrected count, latency-matched
// history and a valid/ready holding register with sticky overflow.
module tdc_fine_interp
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS = 64,
    parameter int SYNC_LAT = 4,
    parameter int CW       = fine_cw(NUM_TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          signal_in,
    input  logic          edge_pol,
    input  logic          sample,
    input  logic          ovf_clr,
    output logic [CW-1:0] fine_count,
    output logic          fine_edge_ok,
    output logic          fine_valid,
    input  logic          fine_ready,
    output logic          overflow
);

    // Stage C plus SYNC_LAT-2 history entries: the last entry at edge E holds
    // the count of taps captured at edge E-SYNC_LAT.
    localparam int            HIST_D = SYNC_LAT - 1;
    localparam logic [CW-1:0] FULL   = CW'(NUM_TAPS);

    logic [NUM_TAPS-1:0] chain_taps;
    logic [NUM_TAPS-1:0] tap_p0;
    logic [MAX_TAPS-1:0] tap_ext_p0;
    logic [CW-1:0]       raw_p0;
    logic [CW-1:0]       cnt_p0;
    logic [CW-1:0]       hist_p1 [HIST_D];
    logic [CW-1:0]       hist_out;
    logic                edge_ok_nxt;
    logic                fire;

    tdc_carry_chain #(
        .NUM_TAPS (NUM_TAPS)
    ) u_chain (
        .signal_in (signal_in),
        .taps      (chain_taps)
    );

    // Stage T: capture the delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_p0 <= '0;
        end else begin
            tap_p0 <= chain_taps;
        end
    end

    always_comb begin
        tap_ext_p0                 = '0;
        tap_ext_p0[NUM_TAPS-1:0]   = tap_p0;
        raw_p0                     = CW'(tdc_therm2bin(tap_ext_p0, NUM_TAPS));
        cnt_p0                     = (edge_pol == EDGE_FALL) ? (FULL - raw_p0) : raw_p0;
    end

    // Stage C and history: free-running shift, no enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_D; i++) begin
                hist_p1[i] <= '0;
            end
        end else begin
            hist_p1[0] <= cnt_p0;
            for (int i = 1; i < HIST_D; i++) begin
                hist_p1[i] <= hist_p1[i-1];
            end
        end
    end

    assign hist_out    = hist_p1[HIST_D-1];
    assign edge_ok_nxt = (hist_out != '0) && (hist_out != FULL);
    assign fire        = fine_valid & fine_ready;

    // Holding register: a sample is accepted when empty or draining this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_count   <= '0;
            fine_edge_ok <= 1'b0;
            fine_valid   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (sample && (!fine_valid || fire)) begin
                fine_count   <= hist_out;
                fine_edge_ok <= edge_ok_nxt;
                fine_valid   <= 1'b1;
            end else if (fire) begin
                fine_valid   <= 1'b0;
            end

            if (sample && fine_valid && !fire) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_fine_interp.sv
// Directed bench for tdc_fine_interp: tap-pattern table plus hand sequences
// for alignment, backpressure/overflow, fire-and-load and async reset.
module tb_tdc_fine_interp;

    localparam int NT = 64;
    localparam int SL = 4;
    localparam int CW = 7;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          signal_in  = 1'b0;
    logic          edge_pol   = 1'b0;
    logic          sample     = 1'b0;
    logic          ovf_clr    = 1'b0;
    logic          fine_ready = 1'b1;
    logic [CW-1:0] fine_count;
    logic          fine_edge_ok;
    logic          fine_valid;
    logic          overflow;
    logic [NT-1:0] tap_vec    = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NT-1:0] taps;
        logic          pol;
        int            cnt;
        int            ok;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    tdc_fine_interp #(
        .NUM_TAPS (NT),
        .SYNC_LAT (SL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_in    (signal_in),
        .edge_pol     (edge_pol),
        .sample       (sample),
        .ovf_clr      (ovf_clr),
        .fine_count   (fine_count),
        .fine_edge_ok (fine_edge_ok),
        .fine_valid   (fine_valid),
        .fine_ready   (fine_ready),
        .overflow     (overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{64'h0000_0000_FFFF_FFFF, 1'b0, 32, 1};
        tbl[1] = '{64'h0000_0000_004F_EFFF, 1'b0, 20, 1};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 0};
        tbl[3] = '{64'h0000_0000_0000_0000, 1'b0,  0, 0};
        tbl[4] = '{64'h0000_0000_0000_03FF, 1'b1, 54, 1};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1,  0, 0};
        tbl[6] = '{64'h0000_0000_0000_0000, 1'b1, 64, 0};
        tbl[7] = '{64'h0000_0000_0000_0001, 1'b0,  1, 1};
        tbl[8] = '{64'h0000_0000_0000_0002, 1'b0,  1, 1};
        tbl[9] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 63, 1};

        force dut.chain_taps = tap_vec;

        #2;
        chk("reset_count", int'(fine_count), 0);
        chk("reset_ok", int'(fine_edge_ok), 0);
        chk("reset_valid", int'(fine_valid), 0);
        chk("reset_ovf", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Steady tap patterns, one sample each, consumer always ready
        for (int i = 0; i < 10; i++) begin
            edge_pol = tbl[i].pol;
            tap_vec  = tbl[i].taps;
            repeat (SL + 1) @(negedge clk);
            sample = 1'b1;
            @(negedge clk);
            sample = 1'b0;
            chk($sformatf("tbl%0d_count", i), int'(fine_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_ok", i), int'(fine_edge_ok), tbl[i].ok);
            chk($sformatf("tbl%0d_valid", i), int'(fine_valid), 1);
            @(negedge clk);
            chk($sformatf("tbl%0d_drain", i), int'(fine_valid), 0);
        end

        // Alignment: one-edge tap pulse seen only by the sample SYNC_LAT later
        edge_pol = 1'b0;
        tap_vec  = '0;
        repeat (SL + 1) @(negedge clk);
        tap_vec = 64'h0000_0000_FFFF_FFFF;
        @(negedge clk);
        tap_vec = '0;
        @(negedge clk);
        @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        chk("align_early_count", int'(fine_count), 0);
        chk("align_early_valid", int'(fine_valid), 1);
        @(negedge clk);
        chk("align_hit_count", int'(fine_count), 32);
        chk("align_hit_ok", int'(fine_edge_ok), 1);
        chk("align_hit_valid", int'(fine_valid), 1);
        @(negedge clk);
        sample = 1'b0;
        chk("align_late_count", int'(fine_count), 0);
        chk("align_late_ok", int'(fine_edge_ok), 0);
        @(negedge clk);
        chk("align_drain_valid", int'(fine_valid), 0);
        chk("align_no_ovf", int'(overflow), 0);

        // Backpressure: second back-to-back sample is dropped
        fine_ready = 1'b0;
        tap_vec    = 64'h0000_0000_0000_00FF;
        repeat (SL + 1) @(negedge clk);
        tap_vec = 64'h0000_0000_0000_FFFF;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        chk("bp_first_count", int'(fine_count), 8);
        chk("bp_first_valid", int'(fine_valid), 1);
        chk("bp_first_ovf", int'(overflow), 0);
        @(negedge clk);
        sample = 1'b0;
        chk("bp_held_count", int'(fine_count), 8);
        chk("bp_second_ovf", int'(overflow), 1);
        repeat (2) @(negedge clk);
        chk("bp_ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", int'(overflow), 0);
        sample  = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        sample  = 1'b0;
        ovf_clr = 1'b0;
        chk("bp_set_wins", int'(overflow), 1);
        chk("bp_set_wins_count", int'(fine_count), 8);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr2", int'(overflow), 0);

        // Fire and sample at the same edge: new value replaces old, no overflow
        fine_ready = 1'b1;
        sample     = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("fire_load_count", int'(fine_count), 16);
        chk("fire_load_valid", int'(fine_valid), 1);
        chk("fire_load_ovf", int'(overflow), 0);
        @(negedge clk);
        chk("fire_drain_valid", int'(fine_valid), 0);
        chk("fire_drain_count", int'(fine_count), 16);

        // Async reset while full and overflowed
        fine_ready = 1'b0;
        sample     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample = 1'b0;
        chk("pre_rst_valid", int'(fine_valid), 1);
        chk("pre_rst_ovf", int'(overflow), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(fine_count), 0);
        chk("async_rst_ok", int'(fine_edge_ok), 0);
        chk("async_rst_valid", int'(fine_valid), 0);
        chk("async_rst_ovf", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("post_rst_count", int'(fine_count), 0);
        chk("post_rst_ok", int'(fine_edge_ok), 0);
        chk("post_rst_valid", int'(fine_valid), 1);
        fine_ready = 1'b1;
        repeat (SL + 1) @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("post_rst_resume_count", int'(fine_count), 16);
        chk("post_rst_resume_ok", int'(fine_edge_ok), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
